// File: rtl/vdp_slot_pkg.sv
// Shared types and constants for the MSX slot I/O to VDP request bus bridge.
package vdp_slot_pkg;

  localparam int unsigned VDP_IO_PORTS = 4;
  localparam int unsigned BUS_ADDR_W   = $clog2(VDP_IO_PORTS);
  localparam int unsigned BUS_DATA_W   = 8;
  localparam logic [BUS_DATA_W-1:0] TIMEOUT_DATA = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    RD_REQ,
    RD_DRIVE,
    WAIT_END
  } state_t;

  // Request payload held stable from bus_valid rise until the transfer
  typedef struct packed {
    logic                  write;
    logic [BUS_ADDR_W-1:0] address;
    logic [BUS_DATA_W-1:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/vdp_slot_io_bridge_if.sv
// Internal request/ready bus between the slot bridge and the VDP port decoder.
interface vdp_slot_io_bridge_if;
  import vdp_slot_pkg::*;

  logic                  bus_valid;
  logic                  bus_write;
  logic [BUS_ADDR_W-1:0] bus_address;
  logic [BUS_DATA_W-1:0] bus_wdata;
  logic                  bus_ready;
  logic [BUS_DATA_W-1:0] bus_rdata;

  modport master (
    output bus_valid, bus_write, bus_address, bus_wdata,
    input  bus_ready, bus_rdata
  );

  modport slave (
    input  bus_valid, bus_write, bus_address, bus_wdata,
    output bus_ready, bus_rdata
  );

endinterface

// File: rtl/vdp_slot_sync.sv
// Synchroniser chain for one raw slot strobe, plus a delayed copy for edge detection.
module vdp_slot_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic prev
);

  logic [STAGES-1:0] chain_q;
  logic              prev_q;

  // Flops reset to 1 so a released strobe reads as inactive
  always_ff @(posedge clk) begin
    if (reset) begin
      chain_q <= '1;
      prev_q  <= 1'b1;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], din};
      prev_q  <= chain_q[STAGES-1];
    end
  end

  assign level = chain_q[STAGES-1];
  assign prev  = prev_q;

endmodule

// File: rtl/vdp_slot_io_bridge.sv
// Converts asynchronous Z80 slot I/O cycles in a 4-port window into single-clock
// request/ready transfers, driving slot data direction and /WAIT for reads.
module vdp_slot_io_bridge
  import vdp_slot_pkg::*;
#(
  parameter logic [7:0]  IO_BASE      = 8'h88,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned WAIT_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       slot_iorq_n,
  input  logic       slot_rd_n,
  input  logic       slot_wr_n,
  input  logic [7:0] slot_a,
  input  logic [7:0] slot_d_in,
  output logic [7:0] slot_d_out,
  output logic       slot_data_dir,
  output logic       slot_wait,
  vdp_slot_io_bridge_if.master bus
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_TIMEOUT - 1);

  logic iorq_s, iorq_p, rd_s, rd_p, wr_s, wr_p;

  vdp_slot_sync #(.STAGES(SYNC_STAGES)) u_sync_iorq (
    .clk(clk), .reset(reset), .din(slot_iorq_n), .level(iorq_s), .prev(iorq_p)
  );
  vdp_slot_sync #(.STAGES(SYNC_STAGES)) u_sync_rd (
    .clk(clk), .reset(reset), .din(slot_rd_n), .level(rd_s), .prev(rd_p)
  );
  vdp_slot_sync #(.STAGES(SYNC_STAGES)) u_sync_wr (
    .clk(clk), .reset(reset), .din(slot_wr_n), .level(wr_s), .prev(wr_p)
  );

  logic wr_act, rd_act, wr_rise, rd_rise, addr_hit;

  assign wr_act   = ~iorq_s & ~wr_s;
  assign rd_act   = ~iorq_s & ~rd_s;
  assign wr_rise  = wr_act & ~(~iorq_p & ~wr_p);
  assign rd_rise  = rd_act & ~(~iorq_p & ~rd_p);
  assign addr_hit = (slot_a[7:2] == IO_BASE[7:2]);

  state_t          state_q, state_d;
  bus_req_t        req_q, req_d;
  logic            valid_q, valid_d;
  logic            wait_q, wait_d;
  logic            dir_q, dir_d;
  logic [7:0]      dout_q, dout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= '0;
      valid_q <= 1'b0;
      wait_q  <= 1'b0;
      dir_q   <= 1'b0;
      dout_q  <= 8'h00;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      wait_q  <= wait_d;
      dir_q   <= dir_d;
      dout_q  <= dout_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    valid_d = valid_q;
    wait_d  = wait_q;
    dir_d   = dir_q;
    dout_d  = dout_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        // A write edge takes priority over a coincident (illegal) read edge
        if (wr_rise && addr_hit) begin
          req_d   = '{write: 1'b1, address: slot_a[1:0], wdata: slot_d_in};
          valid_d = 1'b1;
          state_d = WR_REQ;
        end else if (rd_rise && addr_hit) begin
          req_d.write   = 1'b0;
          req_d.address = slot_a[1:0];
          valid_d       = 1'b1;
          wait_d        = 1'b1;
          cnt_d         = '0;
          state_d       = RD_REQ;
        end
      end

      WR_REQ: begin
        if (bus.bus_ready) begin
          valid_d = 1'b0;
          state_d = WAIT_END;
        end
      end

      RD_REQ: begin
        if (bus.bus_ready) begin
          dout_d  = bus.bus_rdata;
          valid_d = 1'b0;
          dir_d   = 1'b1;
          wait_d  = 1'b0;
          state_d = RD_DRIVE;
        end else if (cnt_q == CNT_LAST) begin
          // Core never answered: release the CPU with open-bus data
          dout_d  = TIMEOUT_DATA;
          valid_d = 1'b0;
          dir_d   = 1'b1;
          wait_d  = 1'b0;
          state_d = RD_DRIVE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RD_DRIVE: begin
        if (!rd_act) begin
          dir_d   = 1'b0;
          state_d = IDLE;
        end
      end

      WAIT_END: begin
        if (!wr_act && !rd_act) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign slot_d_out      = dout_q;
  assign slot_data_dir   = dir_q;
  assign slot_wait       = wait_q;
  assign bus.bus_valid   = valid_q;
  assign bus.bus_write   = req_q.write;
  assign bus.bus_address = req_q.address;
  assign bus.bus_wdata   = req_q.wdata;

endmodule
